// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period and high time of an asynchronous input signal in
//   units of clk cycles.
//
//   Ports:
//     clk        system clock, all logic on its rising edge
//     rst        asynchronous active-high reset
//     en         measurement enable (synchronous to clk)
//     sig_in     measured signal, asynchronous to clk
//     period     last measured period in clk cycles
//     high_time  last measured high time in clk cycles
//     meas_valid one-cycle pulse when period/high_time update
//     timeout    sticky: no rising edge seen within TIMEOUT cycles
//
//   state | meaning
//   IDLE  | disabled, counters cleared, results held
//   ARM   | waiting for the first rise of a new measurement
//   MEAS  | counting between rises, results reported on every rise
module clk_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_ARM = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] high_lat, high_lat_nxt;
    logic             fall_seen, fall_seen_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             valid_nxt, timeout_nxt;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            high_lat   <= '0;
            fall_seen  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hcnt       <= hcnt_nxt;
            high_lat   <= high_lat_nxt;
            fall_seen  <= fall_seen_nxt;
            period     <= period_nxt;
            high_time  <= high_time_nxt;
            meas_valid <= valid_nxt;
            timeout    <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hcnt_nxt      = hcnt;
        high_lat_nxt  = high_lat;
        fall_seen_nxt = fall_seen;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;

        if (!en) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            hcnt_nxt      = '0;
            high_lat_nxt  = '0;
            fall_seen_nxt = 1'b0;
            timeout_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    // cnt counts waiting cycles here; TIMEOUT edges in ARM flag a timeout
                    if (rise) begin
                        state_nxt     = MEAS;
                        cnt_nxt       = ONE;
                        hcnt_nxt      = ONE;
                        fall_seen_nxt = 1'b0;
                    end else if (cnt == TO_ARM) begin
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                MEAS: begin
                    // rise is checked first so an edge landing on cnt==TIMEOUT still reports
                    if (rise) begin
                        period_nxt    = cnt;
                        high_time_nxt = fall_seen ? high_lat : cnt;
                        valid_nxt     = 1'b1;
                        timeout_nxt   = 1'b0;
                        cnt_nxt       = ONE;
                        hcnt_nxt      = ONE;
                        fall_seen_nxt = 1'b0;
                    end else if (cnt == TO_CNT) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = ARM;
                        cnt_nxt     = '0;
                        hcnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                        if (fall && !fall_seen) begin
                            high_lat_nxt  = hcnt;
                            fall_seen_nxt = 1'b1;
                        end else if (s2 && !fall_seen) begin
                            hcnt_nxt = hcnt + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000, number of clk cycles without a rising edge before a timeout is declared; legal range 4 .. 2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  measurement enable, synchronous to clk.
REQ-006 SHALL have port sig_in  input  1  measured signal (e.g. divided clock), asynchronous to clk.
REQ-007 SHALL have port period  output  CNT_W  last measured period, in clk cycles.
REQ-008 SHALL have port high_time  output  CNT_W  last measured high time, in clk cycles.
REQ-009 SHALL have port meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-010 SHALL have port timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 SHALL implement FSM states IDLE, ARM, MEAS.
REQ-013 IDLE: entered when en=0 from any state; counters held at 0; timeout cleared; period/high_time hold their values.
REQ-014 IDLE -> ARM on the first cycle with en=1.
REQ-015 ARM: wait for rise; on rise -> MEAS, cnt <= 1, hcnt <= 1; no output update.
REQ-016 MEAS: cnt increments by 1 each cycle; hcnt increments each cycle while s2=1 and no fall has been seen since the last rise.
REQ-017 MEAS, on fall: high_lat <= hcnt; hcnt stops.
REQ-018 MEAS, on rise: period <= cnt, high_time <= high_lat, meas_valid <= 1 for exactly one cycle, timeout <= 0, cnt <= 1, hcnt <= 1; remain in MEAS.
REQ-019 Result: period = number of clk cycles between consecutive detected rises; high_time = number of cycles between a rise and the following fall.
REQ-020 Rise with no intervening fall SHALL be impossible; if s2 never fell (high_lat not updated since last rise), high_time <= cnt.
REQ-021 Latency: a sig_in rising edge sampled at posedge N is detected as rise at cycle N+2; meas_valid asserts at cycle N+3.
REQ-022 MEAS timeout: when cnt reaches TIMEOUT with no rise, timeout <= 1, FSM -> ARM, cnt/hcnt <= 0; period/high_time unchanged.
REQ-023 Rise and timeout in the same cycle: rise wins; measurement is reported and timeout is not set.
REQ-024 ARM SHALL also time out: after TIMEOUT cycles in ARM without rise, timeout <= 1 and the ARM cycle count restarts.
REQ-025 timeout SHALL stay 1 until the next meas_valid, en=0, or rst.
REQ-026 Counters SHALL never wrap; TIMEOUT < 2^CNT_W guarantees this.
REQ-027 en falling mid-measurement SHALL abort immediately (next cycle IDLE), with no meas_valid.
REQ-028 Resolution is one clk cycle; edges shorter than two clk cycles are not guaranteed to be detected.

Reset
REQ-029 On rst=1: state=IDLE, s1/s2/s3=0, cnt=hcnt=high_lat=0, period=0, high_time=0, meas_valid=0, timeout=0, asynchronously.
REQ-030 Reset asserted mid-measurement SHALL discard the partial measurement; after release, the first rise only re-arms (ARM -> MEAS).

Verification
REQ-031 en=1, sig_in pattern high 2 / low 1 clk cycles, repeating -> from the second rise onward, meas_valid every 3 cycles with period=3, high_time=2.
REQ-032 en=1, sig_in high 5 / low 5 -> period=10, high_time=5; first meas_valid exactly 3 cycles after the second rising edge is sampled.
REQ-033 TIMEOUT=20, sig_in held 0 after one rise -> timeout=1 twenty cycles after cnt=1, no meas_valid; toggling resumes -> timeout clears at the first meas_valid.
REQ-034 Edge landing on the cycle cnt=TIMEOUT -> meas_valid=1, period=TIMEOUT, timeout stays 0.
REQ-035 en dropped mid-period, then re-raised -> no meas_valid until two new rises are seen; period/high_time keep their old values throughout.
REQ-036 rst pulsed mid-measurement -> all outputs 0 immediately; the measurement resumes only after ARM plus a full period.
